accum32_stream: RTL and testbench
=================================

Name: accum32_stream

Overview:
- Streaming 32-bit accumulator that sits directly downstream of the team's 32-bit ripple-carry adder (Adder32bit).
- Consumes a valid/ready operand stream, feeds each operand plus the running sum into one Adder32bit instance (cin=0), and registers the adder's s/cout each accepted beat.
- On the frame's last beat, presents the final sum with sticky unsigned-carry and signed-overflow flags and a beat count to the downstream consumer.

Parameters:
- CNT_W, 8, width of beat counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards the frame and returns to IDLE.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand ready.
- in_data  in  32  operand.
- in_last  in  1  marks the final operand of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_sum  out  32  accumulated sum, modulo 2^32.
- out_carry  out  1  sticky OR of adder cout over the frame.
- out_ovf  out  1  sticky two's-complement overflow over the frame.
- out_count  out  CNT_W  beats accepted in the frame, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; sum, carry, ovf, count all cleared.
  - out_valid=0, in_ready=0 while reset is asserted.
  - in_ready=1 from the first clock edge after deassertion.
- Beat accept: in_valid && in_ready at a rising edge.
- Adder usage:
  - a=sum_q, b=in_data, cin=0.
  - Next sum = adder s.
  - carry_q |= cout.
  - ovf_q |= (sum_q[31]==in_data[31]) && (s[31]!=sum_q[31]).
  - count_q = count_q+1, holding at all-ones once reached.
- States:
  - IDLE: sum/flags/count are zero; in_ready=1. Accepting a beat with in_last=0 moves to ACC; with in_last=1 moves to HOLD.
  - ACC: in_ready=1. Each beat accumulates. A beat with in_last=1 accumulates and moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_* are registered and stable while out_ready=0. Handshake (out_valid && out_ready) clears sum/flags/count and moves to IDLE.
- Latency:
  - out_valid rises on the clock edge that accepts the last beat, i.e. visible the cycle after acceptance.
  - The next frame's first beat is accepted no earlier than the cycle after the output handshake. Minimum 2-cycle turnaround; there is no result/input overlap.
- Single-beat frame: IDLE -> HOLD directly. out_sum=in_data, out_count=1, carry=0, ovf=0.
- flush=1 at an edge:
  - Forces IDLE and clears all state, in any state, including HOLD with a pending result (the result is dropped).
  - Takes precedence over a simultaneous beat accept or output handshake. That beat is discarded and the handshake is not counted as a delivery.
  - in_ready stays 1 during flush; a flushed beat is consumed and lost.
- Wrap-around:
  - The sum wraps modulo 2^32.
  - out_carry and out_ovf are sticky per frame and cleared only by handshake, flush, or reset.
- in_data and in_last are ignored when in_valid=0.
- Reset mid-frame or mid-HOLD: immediate return to reset values; no partial result is emitted.
- Outputs out_sum, out_carry, out_ovf, out_count are driven from registers. Their values are meaningful only when out_valid=1 and are held at accumulated values otherwise.

Test Plan:
- Reset, then frame 5, 7, 9 (last) with out_ready=1 -> out_valid for exactly 1 cycle; out_sum=21, count=3, carry=0, ovf=0; in_ready back to 1 the next cycle.
- Frame 0xFFFFFFFF, 0x00000002 (last) -> out_sum=0x00000001, carry=1, ovf=0. Frame 0x7FFFFFFF, 0x00000001 (last) -> out_sum=0x80000000, carry=0, ovf=1.
- Single-beat frame 0xDEADBEEF (last) with out_ready=0 for 4 cycles -> out_valid stays high with out_sum stable at 0xDEADBEEF, count=1, in_ready=0 throughout; completes when out_ready=1.
- Frame 10, 20, then flush asserted on the cycle a third beat 30 (last) is offered -> no out_valid. A following frame of 4 (last) yields out_sum=4, count=1.
- CNT_W=2, frame of 5 beats of value 1 -> out_sum=5, out_count=3 (saturated).
- Assert rst_n=0 asynchronously mid-frame (between clock edges) after beats 1, 2 -> out_valid and in_ready drop immediately. After release, frame 3 (last) -> out_sum=3, count=1.

Source files
------------

// File: rtl/accum32_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | accum32_stream : valid/ready 32-bit frame accumulator built on the      |
// |                  Adder32bit ripple-carry adder, with sticky C/V flags   |
// | Revision       : 1.0                                                    |
// +------------------------------------------------------------------------+

module Adder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic carry;

    // Carry held in a procedural variable so the chain is a plain ripple.
    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 0; i < 32; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module accum32_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             live_q;

    logic [31:0]      add_s;
    logic             add_cout;
    logic             beat_ovf;
    logic             accept;
    logic             deliver;

    Adder32bit u_adder (
        .a    (sum_q),
        .b    (in_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    assign beat_ovf = (sum_q[31] == in_data[31]) && (add_s[31] != sum_q[31]);

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = live_q && (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (flush) begin
            state_d = ST_IDLE;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        sum_d   = add_s;
                        carry_d = carry_q | add_cout;
                        ovf_d   = ovf_q | beat_ovf;
                        count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
                        state_d = in_last ? ST_HOLD : ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (deliver) begin
                        state_d = ST_IDLE;
                        sum_d   = '0;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            live_q  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_accum32_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_accum32_stream : table-driven frames with a result scoreboard plus   |
// |                     hold, flush, saturation and reset sequences         |
// | Revision          : 1.0                                                 |
// +------------------------------------------------------------------------+

module tb_accum32_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_carry, out_ovf;
    logic [31:0] out_sum;
    logic [7:0]  out_count;

    logic        d2_flush, d2_in_valid, d2_in_last, d2_out_ready;
    logic [31:0] d2_in_data;
    logic        d2_in_ready, d2_out_valid, d2_out_carry, d2_out_ovf;
    logic [31:0] d2_out_sum;
    logic [1:0]  d2_out_count;

    accum32_stream #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_count(out_count)
    );

    accum32_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data), .in_last(d2_in_last),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_sum(d2_out_sum),
        .out_carry(d2_out_carry), .out_ovf(d2_out_ovf), .out_count(d2_out_count)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic [7:0]  count;
    } exp_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] beats;
        exp_t             e;
    } vec_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   deliveries = 0;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] s, input logic c,
                                input logic o, input logic [7:0] cnt);
        vec_t v;
        v.n        = 3'(n);
        v.beats    = '0;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.e.sum    = s;
        v.e.carry  = c;
        v.e.ovf    = o;
        v.e.count  = cnt;
        return v;
    endfunction

    // A handshake is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready && !flush) begin
            deliveries++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected delivery: actual sum %0h, required no result", out_sum);
            end else begin
                e = sb.pop_front();
                check("sb sum",   out_sum,   e.sum);
                check("sb carry", out_carry, e.carry);
                check("sb ovf",   out_ovf,   e.ovf);
                check("sb count", out_count, e.count);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic last);
        bit ok;
        int waited;
        ok       = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept timeout: in_ready low for %0d cycles, required 1", waited);
        end
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if (i == int'(v.n) - 1) sb.push_back(v.e);
            send_beat(v.beats[i], i == int'(v.n) - 1);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = $urandom;
        in_last      = 1'b1;
        out_ready    = 1'b1;
        d2_flush     = 1'b0;
        d2_in_valid  = 1'b0;
        d2_in_data   = '0;
        d2_in_last   = 1'b0;
        d2_out_ready = 1'b0;

        tbl[0] = mk(3, 32'd5,        32'd7,        32'd9,        32'd21,       1'b0, 1'b0, 8'd3);
        tbl[1] = mk(2, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h00000001, 1'b1, 1'b0, 8'd2);
        tbl[2] = mk(2, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 1'b0, 1'b1, 8'd2);
        tbl[3] = mk(2, 32'h80000000, 32'h80000000, 32'h0,        32'h00000000, 1'b1, 1'b1, 8'd2);
        tbl[4] = mk(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, 8'd3);
        tbl[5] = mk(3, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 32'h80000001, 1'b0, 1'b1, 8'd3);
        tbl[6] = mk(3, 32'hFFFFFFFF, 32'h00000002, 32'h00000003, 32'h00000004, 1'b1, 1'b0, 8'd3);
        tbl[7] = mk(1, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 1'b0, 1'b0, 8'd1);

        #2;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready",  in_ready,  1'b0);
        check("reset out_sum",   out_sum,   32'h0);
        check("reset out_count", out_count, 8'h0);
        check("reset out_flags", {out_carry, out_ovf}, 2'b00);
        #21;
        rst_n = 1'b1;
        #1;
        check("ready before first edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("ready after first edge", in_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i]);
            check($sformatf("tbl%0d out_valid high", i), out_valid, 1'b1);
            check($sformatf("tbl%0d in_ready low", i),   in_ready,  1'b0);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d out_valid one cycle", i), out_valid, 1'b0);
            check($sformatf("tbl%0d in_ready back", i),       in_ready,  1'b1);
        end

        // Result held under back-pressure
        out_ready = 1'b0;
        sb.push_back({32'hDEADBEEF, 1'b0, 1'b0, 8'd1});
        send_beat(32'hDEADBEEF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hold%0d out_valid", k), out_valid, 1'b1);
            check($sformatf("hold%0d out_sum", k),   out_sum,   32'hDEADBEEF);
            check($sformatf("hold%0d out_count", k), out_count, 8'd1);
            check($sformatf("hold%0d in_ready", k),  in_ready,  1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold released", out_valid, 1'b0);
        check("hold delivered", sb.size(), 0);

        // Flush on the cycle the last beat is offered
        send_beat(32'd10, 1'b0);
        send_beat(32'd20, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd30;
        in_last  = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("ready during flush", in_ready, 1'b1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", out_valid, 1'b0);
        check("flush out_sum",   out_sum,   32'h0);
        check("flush out_count", out_count, 8'h0);
        sb.push_back({32'd4, 1'b0, 1'b0, 8'd1});
        send_beat(32'd4, 1'b1);
        @(posedge clk);
        #1;

        // Flush beats a simultaneous output handshake
        out_ready = 1'b0;
        send_beat(32'd55, 1'b1);
        check("pre-flush hold", out_valid, 1'b1);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("hold flush out_valid", out_valid, 1'b0);
        check("hold flush out_sum",   out_sum,   32'h0);

        // Count saturation on the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            d2_in_valid = 1'b1;
            d2_in_data  = 32'd1;
            d2_in_last  = (k == 4);
            @(negedge clk);
            check($sformatf("sat beat%0d ready", k), d2_in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        d2_in_valid = 1'b0;
        check("sat out_valid", d2_out_valid, 1'b1);
        check("sat out_sum",   d2_out_sum,   32'd5);
        check("sat out_count", d2_out_count, 2'd3);
        check("sat flags",     {d2_out_carry, d2_out_ovf}, 2'b00);
        d2_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sat delivered", d2_out_valid, 1'b0);

        // Asynchronous reset while holding a result
        out_ready = 1'b0;
        send_beat(32'd77, 1'b1);
        check("pre-reset hold", out_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst hold out_valid", out_valid, 1'b0);
        check("rst hold in_ready",  in_ready,  1'b0);
        check("rst hold out_sum",   out_sum,   32'h0);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst hold recover", in_ready, 1'b1);

        // Asynchronous reset mid-frame
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst frame in_ready",  in_ready,  1'b0);
        check("rst frame out_valid", out_valid, 1'b0);
        check("rst frame out_count", out_count, 8'h0);
        check("rst frame out_sum",   out_sum,   32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst frame ready pre-edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst frame ready post-edge", in_ready, 1'b1);
        sb.push_back({32'd3, 1'b0, 1'b0, 8'd1});
        send_beat(32'd3, 1'b1);
        @(posedge clk);
        #1;
        check("final frame done", out_valid, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);
        check("delivery count", deliveries, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
